// File: rtl/step_seq_pkg.sv
// Shared widths and FSM encoding for the step-map sequencer.
package step_seq_pkg;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } step_seq_state_t;

endpackage

// File: rtl/step_map5.sv
// Combinational 5-bit step map f: an invertible XOR mix of the input bits
// followed by a +4 (mod 32) ripple, so f is a permutation of 0..31.
module step_map5 (
  input  logic [4:0] x,
  output logic [4:0] y
);

  logic [4:0] mix;

  // Linear mixing layer (upper-triangular, hence invertible).
  assign mix[0] = x[0] ^ x[2] ^ x[3];
  assign mix[1] = x[1] ^ x[2] ^ x[3] ^ x[4];
  assign mix[2] = x[2] ^ x[3] ^ x[4];
  assign mix[3] = x[3];
  assign mix[4] = x[4];

  // Add constant 4: bits 1:0 pass, carry chain starts at bit 2.
  assign y[0] = mix[0];
  assign y[1] = mix[1];
  assign y[2] = ~mix[2];
  assign y[3] = mix[3] ^ mix[2];
  assign y[4] = mix[4] ^ (mix[3] & mix[2]);

endmodule

// File: rtl/step_map_sequencer.sv
// Iterates the 5-bit step map from a seed for a programmed number of steps and
// returns the final state over valid/ready. Optional early stop on orbit
// closure when STEP_SEQ_ORBIT_DETECT_EN is defined.
module step_map_sequencer
  import step_seq_pkg::*;
#(
  parameter int unsigned STATE_W = step_seq_pkg::STATE_W,
  parameter int unsigned CNT_W   = step_seq_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STATE_W-1:0] seed,
  input  logic [CNT_W-1:0]   steps,
  input  logic               abort,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] result,
  output logic [CNT_W-1:0]   period
);

  step_seq_state_t fsm_q, fsm_d;

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] seed_q, seed_d;
  logic [STATE_W-1:0] result_q, result_d;
  logic [STATE_W-1:0] f_out;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

`ifdef STEP_SEQ_ORBIT_DETECT_EN
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             orbit_hit_c;

  assign orbit_hit_c = (f_out == seed_q);
`endif

  step_map5 u_map (
    .x (state_q),
    .y (f_out)
  );

  // Next-state and registered-output logic.
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    period_d = period_q;
    valid_d  = valid_q;
`ifdef STEP_SEQ_ORBIT_DETECT_EN
    steps_d  = steps_q;
`endif

    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = seed;
          seed_d  = seed;
          cnt_d   = steps;
`ifdef STEP_SEQ_ORBIT_DETECT_EN
          steps_d = steps;
`endif
          if (steps == '0) begin
            fsm_d    = DONE;
            result_d = seed;
            period_d = '0;
            valid_d  = 1'b1;
          end else begin
            fsm_d = RUN;
          end
        end
      end

      RUN: begin
        // Abort wins over both the final step and an orbit hit.
        if (abort) begin
          fsm_d = IDLE;
        end else begin
          state_d = f_out;
          cnt_d   = cnt_q - CNT_W'(1);
`ifdef STEP_SEQ_ORBIT_DETECT_EN
          if (orbit_hit_c) begin
            fsm_d    = DONE;
            result_d = seed_q;
            period_d = steps_q - cnt_q + CNT_W'(1);
            valid_d  = 1'b1;
          end else if (cnt_q == CNT_W'(1)) begin
            fsm_d    = DONE;
            result_d = f_out;
            period_d = '0;
            valid_d  = 1'b1;
          end
`else
          if (cnt_q == CNT_W'(1)) begin
            fsm_d    = DONE;
            result_d = f_out;
            period_d = '0;
            valid_d  = 1'b1;
          end
`endif
        end
      end

      DONE: begin
        if (valid_q && out_ready) begin
          fsm_d   = IDLE;
          valid_d = 1'b0;
        end
      end

      default: begin
        fsm_d   = IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (fsm_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      seed_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      period_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      period_q <= period_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

`ifdef STEP_SEQ_ORBIT_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_q <= '0;
    end else begin
      steps_q <= steps_d;
    end
  end
`endif

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign result    = result_q;
  assign period    = period_q;

endmodule

// File: tb/tb_step_map_sequencer.sv
// Self-checking bench for step_map_sequencer: table of runs plus handshake-hold,
// abort and mid-run reset sequences, with a queue scoreboard of expected results.
module tb_step_map_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] seed_i;
  logic [7:0] steps_i;
  logic       abort;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] result;
  logic [7:0] period;

  step_map_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed_i),
    .steps     (steps_i),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .period    (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] r;
    logic [7:0] p;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [4:0] seed;
    logic [7:0] steps;
    logic [4:0] r;
    logic [7:0] p;
    int         cyc;
  } vec_t;

  localparam int NVEC = 10;

  exp_t       sb[$];
  vec_t       vecs[NVEC];
  int         n_cmp;
  int         n_err;
  logic [4:0] last_r;
  logic [7:0] last_p;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference map: XOR the column image of each set bit, then add 4 mod 32.
  function automatic logic [4:0] model_f(input logic [4:0] x);
    logic [4:0] cols [5];
    logic [4:0] g;
    cols[0] = 5'b00001;
    cols[1] = 5'b00010;
    cols[2] = 5'b00111;
    cols[3] = 5'b01111;
    cols[4] = 5'b10110;
    g = '0;
    for (int i = 0; i < 5; i++) if (x[i]) g = g ^ cols[i];
    return 5'((int'(g) + 4) % 32);
  endfunction

  task automatic model_run(input logic [4:0] sd, input logic [7:0] st,
                           output logic [4:0] r, output logic [7:0] p, output int cyc);
    logic [4:0] s;
    s   = sd;
    p   = '0;
    cyc = int'(st);
    for (int i = 1; i <= int'(st); i++) begin
      s = model_f(s);
`ifdef STEP_SEQ_ORBIT_DETECT_EN
      if (s == sd) begin
        p   = 8'(i);
        cyc = i;
        break;
      end
`endif
    end
    r = s;
  endtask

  task automatic do_start(input logic [4:0] sd, input logic [7:0] st);
    @(negedge clk);
    seed_i  = sd;
    steps_i = st;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cyc);
    int b;
    b   = budget;
    cyc = 0;
    while (!out_valid && b > 0) begin
      if (busy) cyc++;
      @(negedge clk);
      b--;
    end
    if (!out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: out_valid got 0 expected 1", name);
    end
  endtask

  task automatic finish_run(input string name, input int cyc);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: got empty scoreboard expected entry", name);
      return;
    end
    e = sb.pop_front();
    check({name, "_result"}, 32'(result), 32'(e.r));
    check({name, "_period"}, 32'(period), 32'(e.p));
    check({name, "_busy_cycles"}, 32'(cyc), 32'(e.cyc));
    check({name, "_busy_done"}, 32'(busy), 32'(0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'(0));
    last_r = e.r;
    last_p = e.p;
  endtask

  task automatic run_vec(input int i);
    exp_t e;
    int   cyc;
    string nm;
    nm    = $sformatf("vec%0d", i);
    e.r   = vecs[i].r;
    e.p   = vecs[i].p;
    e.cyc = vecs[i].cyc;
    sb.push_back(e);
    do_start(vecs[i].seed, vecs[i].steps);
    wait_done(nm, int'(vecs[i].steps) + 20, cyc);
    finish_run(nm, cyc);
  endtask

  initial begin
    int   cyc;
    int   vbad;
    exp_t e;

    n_cmp     = 0;
    n_err     = 0;
    last_r    = '0;
    last_p    = '0;
    rst_n     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    seed_i    = '0;
    steps_i   = '0;

    // Golden rows use fixed values; the rest come from the reference model.
    vecs[0] = '{5'd0,  8'd3, 5'd16, 8'd0, 3};
    vecs[1] = '{5'd11, 8'd0, 5'd11, 8'd0, 0};
    vecs[2] = '{5'd0,  8'd1, 5'd4,  8'd0, 1};
    vecs[3] = '{5'd4,  8'd1, 5'd11, 8'd0, 1};
    vecs[4] = '{5'd11, 8'd1, 5'd16, 8'd0, 1};
    vecs[5] = '{5'd16, 8'd1, 5'd26, 8'd0, 1};
    vecs[6].seed = 5'd0;  vecs[6].steps = 8'd255;
    vecs[7].seed = 5'd5;  vecs[7].steps = 8'd17;
    vecs[8].seed = 5'd31; vecs[8].steps = 8'd40;
    vecs[9].seed = 5'd16; vecs[9].steps = 8'd2;
    for (int i = 6; i < NVEC; i++)
      model_run(vecs[i].seed, vecs[i].steps, vecs[i].r, vecs[i].p, vecs[i].cyc);

    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_period", 32'(period), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Hold DONE with out_ready low while start is pulsed.
    e.r = 5'd16; e.p = 8'd0; e.cyc = 3;
    sb.push_back(e);
    do_start(5'd0, 8'd3);
    wait_done("hold", 30, cyc);
    vbad = 0;
    for (int k = 0; k < 5; k++) begin
      start   = 1'b1;
      seed_i  = 5'd7;
      steps_i = 8'd5;
      @(negedge clk);
      if (!(out_valid === 1'b1 && result === 5'd16 && busy === 1'b0)) vbad++;
    end
    check("hold_stable", 32'(vbad), 32'(0));
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    check("hold_release_valid", 32'(out_valid), 32'(0));
    check("hold_release_busy", 32'(busy), 32'(0));
    e = sb.pop_front();
    check("hold_result", 32'(result), 32'(e.r));
    last_r = e.r;
    last_p = e.p;
    run_vec(7);

    // Abort in the 10th RUN cycle.
    do_start(5'd0, 8'd200);
    repeat (9) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    vbad = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) vbad++;
      @(negedge clk);
    end
    check("abort_no_valid", 32'(vbad), 32'(0));
    check("abort_result", 32'(result), 32'(last_r));
    check("abort_period", 32'(period), 32'(last_p));

    // Reset between edges in the middle of a run.
    do_start(5'd0, 8'd200);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'(0));
    check("mrst_valid", 32'(out_valid), 32'(0));
    check("mrst_result", 32'(result), 32'(0));
    check("mrst_period", 32'(period), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0);
    run_vec(6);

    check("sb_empty", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
